// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if: write-side and read-side valid/ready bus of the TX FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  // FIFO side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo: first-word-fall-through byte FIFO ahead of the UART transmitter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  wire logic                     clk,
  input  wire logic                     rstn,
  input  wire logic                     i_flush,
  input  wire logic                     i_clear_ovf,
  uart_tx_fifo_if.slave                 bus,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic                          o_almost_full,
  output logic                          o_overflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_AFULL = c_CNT_W'(AFULL_LEVEL);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PINC  = c_PTR_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Status decodes come from the count register only, never from the inputs.
  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid  & ~w_full;
  assign w_pop   = bus.out_ready & ~w_empty;

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_almost_full = (r_count >= c_AFULL);
  assign o_overflow    = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PINC;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PINC;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_ONE;
      end
    end
  end

  // A rejected write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (bus.in_valid && w_full) begin
      r_overflow <= 1'b1;
    end else if (i_clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire
